operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have the ports clk, reset, issue, regfile read, writeback, output and status listed in REQ-002 to REQ-018.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 issue_valid  in  1  decoded instruction offered.
REQ-005 issue_ready  out  1  block accepts offered instruction this cycle.
REQ-006 issue_rs1, issue_rs2  in  5 each  source register indices.
REQ-007 issue_rd  in  5  destination index; issue_rd_write  in  1  instruction will write rd.
REQ-008 rf_rs1, rf_rs2  out  5 each  register-file read addresses.
REQ-009 rf_data1, rf_data2  in  32 each  combinational register-file read data (x0 reads 0).
REQ-010 wb_valid  in  1  writeback this cycle, same strobe as register-file write enable.
REQ-011 wb_rd  in  5; wb_data  in  32  writeback destination and value.
REQ-012 op_valid  out  1  operand bundle available downstream.
REQ-013 op_ready  in  1  downstream consumes bundle this cycle.
REQ-014 op_a, op_b  out  32 each  resolved source operands.
REQ-015 op_rd  out  5; op_rd_write  out  1  destination carried with bundle.
REQ-016 pending  out  32  scoreboard, bit i = write to xi outstanding.
REQ-017 All outputs except issue_ready, rf_rs1, rf_rs2 SHALL be registered.
REQ-018 No parameters; widths fixed at 32-bit data, 5-bit indices.

Function
REQ-019 rf_rs1/rf_rs2 SHALL equal issue_rs1/issue_rs2 combinationally every cycle.
REQ-020 Source s is hazardous when s!=0, pending[s]=1, and NOT (wb_valid and wb_rd==s).
REQ-021 WAW hazard when issue_rd_write=1, issue_rd!=0, pending[issue_rd]=1, and NOT (wb_valid and wb_rd==issue_rd).
REQ-022 issue_ready SHALL be (!op_valid || op_ready) && no rs1, rs2 or WAW hazard; independent of issue_valid.
REQ-023 Accept = issue_valid && issue_ready; on accept op_a/op_b/op_rd/op_rd_write load and op_valid=1 next cycle (latency 1).
REQ-024 Operand resolution: index 0 -> 0; else wb_valid && wb_rd==index && wb_rd!=0 -> wb_data; else rf_data.
REQ-025 On accept with issue_rd_write=1 and issue_rd!=0, pending[issue_rd] SHALL set next cycle.
REQ-026 wb_valid with wb_rd!=0 SHALL clear pending[wb_rd]; wb to a non-pending index is ignored by scoreboard, still forwarded.
REQ-027 Same-cycle set and clear of one bit: set wins.
REQ-028 pending[0] SHALL never be 1.
REQ-029 op_valid=1 and op_ready=0: all op_* outputs held stable; issue_ready=0.
REQ-030 op_ready=1 without accept: op_valid clears next cycle; op_a/op_b/op_rd hold values (don't-care).
REQ-031 op_ready=1 with accept: new bundle replaces old, op_valid stays 1 (full throughput, back-to-back).
REQ-032 Captured operands SHALL NOT change after later writebacks.

Reset
REQ-033 While reset=1: op_valid=0, op_a=0, op_b=0, op_rd=0, op_rd_write=0, pending=0.
REQ-034 Reset mid-stall or mid-hold SHALL drop the in-flight bundle; writebacks arriving after reset only update nothing (pending already 0).
REQ-035 First accept possible on the first rising edge after reset deasserts.

Verification
REQ-036 rf x5=0x11, issue rs1=5 rs2=0 rd=7 write=1, op_ready=1 -> next cycle op_valid=1, op_a=0x11, op_b=0, pending=0x80.
REQ-037 pending[7]=1, issue rs1=7 -> issue_ready=0 each cycle; wb_valid rd=7 data=0xDEAD -> same cycle issue_ready=1, op_a=0xDEAD, pending[7]=0 next.
REQ-038 op_valid=1, op_ready=0 for 3 cycles with issue_valid=1 -> issue_ready=0, op_a unchanged; op_ready=1 -> new bundle next cycle.
REQ-039 pending[3]=1, issue rd=3 write=1 with wb_valid rd=3 same cycle -> accepted, pending[3]=1 after edge (set wins).
REQ-040 issue rd=0 write=1 -> pending stays 0; rs1=0 with wb rd=0 data=0xFF -> op_a=0.
REQ-041 reset pulse while pending=0x0000_0F00 and op_valid=1 -> pending=0, op_valid=0 asynchronously.

Source files
------------

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with scoreboard, writeback bypass and one-entry output register
// Resolves source operands, blocks on RAW/WAW hazards and hands a registered bundle downstream.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_write,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  op_rd,
    output logic        op_rd_write,
    output logic [31:0] pending
);

    logic        op_valid_q, op_valid_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [4:0]  op_rd_q, op_rd_d;
    logic        op_rd_write_q, op_rd_write_d;
    logic [31:0] pending_q, pending_d;

    logic        rs1_hazard;
    logic        rs2_hazard;
    logic        waw_hazard;
    logic        accept;
    logic        wb_live;

    // A writeback landing this cycle retires the outstanding write, so it never blocks.
    function automatic logic is_hazard(input logic [4:0]  idx,
                                       input logic [31:0] pend,
                                       input logic        wbv,
                                       input logic [4:0]  wbrd);
        return (idx != 5'd0) && pend[idx] && !(wbv && (wbrd == idx));
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0]  idx,
                                            input logic [31:0] rf_val,
                                            input logic        wbv,
                                            input logic [4:0]  wbrd,
                                            input logic [31:0] wbd);
        if (idx == 5'd0) begin
            return 32'd0;
        end else if (wbv && (wbrd == idx)) begin
            return wbd;
        end
        return rf_val;
    endfunction

    assign rf_rs1  = issue_rs1;
    assign rf_rs2  = issue_rs2;
    assign wb_live = wb_valid && (wb_rd != 5'd0);

    always_comb begin
        rs1_hazard  = is_hazard(issue_rs1, pending_q, wb_valid, wb_rd);
        rs2_hazard  = is_hazard(issue_rs2, pending_q, wb_valid, wb_rd);
        waw_hazard  = issue_rd_write && is_hazard(issue_rd, pending_q, wb_valid, wb_rd);
        issue_ready = (!op_valid_q || op_ready) && !rs1_hazard && !rs2_hazard && !waw_hazard;
        accept      = issue_valid && issue_ready;
    end

    always_comb begin
        op_valid_d    = op_valid_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_rd_d       = op_rd_q;
        op_rd_write_d = op_rd_write_q;
        pending_d     = pending_q;

        if (accept) begin
            op_valid_d    = 1'b1;
            op_a_d        = resolve(issue_rs1, rf_data1, wb_live, wb_rd, wb_data);
            op_b_d        = resolve(issue_rs2, rf_data2, wb_live, wb_rd, wb_data);
            op_rd_d       = issue_rd;
            op_rd_write_d = issue_rd_write;
        end else if (op_ready) begin
            op_valid_d    = 1'b0;
        end

        // Clear first so a same-cycle set of the same bit takes priority.
        if (wb_live) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (accept && issue_rd_write && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_valid_q    <= 1'b0;
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            op_rd_q       <= 5'd0;
            op_rd_write_q <= 1'b0;
            pending_q     <= 32'd0;
        end else begin
            op_valid_q    <= op_valid_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_rd_q       <= op_rd_d;
            op_rd_write_q <= op_rd_write_d;
            pending_q     <= pending_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_rd       = op_rd_q;
    assign op_rd_write = op_rd_write_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
// Directed scenarios plus randomized traffic against a rule-level model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_write;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_rd;
    logic        op_rd_write;
    logic [31:0] pending;

    logic [31:0] rf_mem [32];

    bit          m_pending [32];
    logic        m_op_valid;
    logic [31:0] m_op_a;
    logic [31:0] m_op_b;
    logic [4:0]  m_op_rd;
    logic        m_op_rd_write;

    int n_checks = 0;
    int n_pass   = 0;

    operand_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rd       (issue_rd),
        .issue_rd_write (issue_rd_write),
        .rf_rs1         (rf_rs1),
        .rf_rs2         (rf_rs2),
        .rf_data1       (rf_data1),
        .rf_data2       (rf_data2),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .op_rd          (op_rd),
        .op_rd_write    (op_rd_write),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    assign rf_data1 = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
    assign rf_data2 = (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];

    function automatic logic [31:0] m_pending_word();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (m_pending[i]) w = w | (32'd1 << i);
        end
        return w;
    endfunction

    function automatic bit m_blocked(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (!m_pending[idx]) return 1'b0;
        if (wb_valid && wb_rd == idx) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        bit slot_free;
        slot_free = !m_op_valid || op_ready;
        return slot_free && !m_blocked(issue_rs1) && !m_blocked(issue_rs2)
               && !(issue_rd_write && m_blocked(issue_rd));
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == idx) return wb_data;
        return rf_mem[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
        m_op_valid    = 1'b0;
        m_op_a        = 32'd0;
        m_op_b        = 32'd0;
        m_op_rd       = 5'd0;
        m_op_rd_write = 1'b0;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rs1      = 5'd0;
        issue_rs2      = 5'd0;
        issue_rd       = 5'd0;
        issue_rd_write = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = 32'd0;
        op_ready       = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr);
        issue_valid    = 1'b1;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_rd       = rd;
        issue_rd_write = wr;
    endtask

    // Advance one clock: predict from current inputs, let the DUT sample, then commit the model and register file.
    task automatic step();
        bit          acc;
        bit          rdy;
        logic [31:0] a;
        logic [31:0] b;
        bit          np [32];
        bit          wbv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        acc = issue_valid && m_ready();
        a   = m_operand(issue_rs1);
        b   = m_operand(issue_rs2);
        rdy = op_ready;
        wbv = wb_valid;
        wrd = wb_rd;
        wd  = wb_data;
        for (int i = 0; i < 32; i++) begin
            np[i] = m_pending[i];
            if (i != 0) begin
                if (acc && issue_rd_write && int'(issue_rd) == i) np[i] = 1'b1;
                else if (wbv && int'(wrd) == i) np[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_pending[i] = np[i];
        if (acc) begin
            m_op_valid    = 1'b1;
            m_op_a        = a;
            m_op_b        = b;
            m_op_rd       = issue_rd;
            m_op_rd_write = issue_rd_write;
        end else if (rdy) begin
            m_op_valid = 1'b0;
        end
        if (wbv && wrd != 5'd0) rf_mem[wrd] = wd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #1;
        n_checks++;
        if ({op_valid, op_rd_write} !== 2'b00) $display("FAIL reset_valid: got %b%b want 00", op_valid, op_rd_write);
        else n_pass++;
        n_checks++;
        if ({op_a, op_b, op_rd, pending} !== 101'd0) $display("FAIL reset_data: got a=%h b=%h rd=%0d pend=%h want 0", op_a, op_b, op_rd, pending);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        issue(5'd1, 5'd2, 5'd0, 1'b0);
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", issue_ready);
        else n_pass++;
        step();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== rf_mem[1] || op_b !== rf_mem[2])
            $display("FAIL first_accept: got v=%b a=%h b=%h want v=1 a=%h b=%h", op_valid, op_a, op_b, rf_mem[1], rf_mem[2]);
        else n_pass++;
    endtask

    task automatic test_basic();
        idle();
        issue(5'd5, 5'd0, 5'd7, 1'b1);
        #1;
        n_checks++;
        if (rf_rs1 !== 5'd5 || rf_rs2 !== 5'd0) $display("FAIL rf_addr: got %0d/%0d want 5/0", rf_rs1, rf_rs2);
        else n_pass++;
        step();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h0)
            $display("FAIL basic_bundle: got v=%b a=%h b=%h want v=1 a=00000011 b=0", op_valid, op_a, op_b);
        else n_pass++;
        n_checks++;
        if (pending !== 32'h80) $display("FAIL basic_pending: got %h want 00000080", pending);
        else n_pass++;
        n_checks++;
        if (op_rd !== 5'd7 || op_rd_write !== 1'b1) $display("FAIL basic_rd: got %0d/%b want 7/1", op_rd, op_rd_write);
        else n_pass++;
    endtask

    task automatic test_raw_hazard();
        idle();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (issue_ready !== 1'b0) $display("FAIL raw_block[%0d]: got %b want 0", c, issue_ready);
            else n_pass++;
            step();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 32'hDEAD;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL raw_release: got %b want 1", issue_ready);
        else n_pass++;
        step();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== 32'hDEAD) $display("FAIL raw_forward: got v=%b a=%h want v=1 a=0000dead", op_valid, op_a);
        else n_pass++;
        n_checks++;
        if (pending[7] !== 1'b0) $display("FAIL raw_clear: got %b want 0", pending[7]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        idle();
        issue(5'd1, 5'd2, 5'd0, 1'b0);
        step();
        held = rf_mem[1];
        op_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (issue_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", c, issue_ready);
            else n_pass++;
            step();
            n_checks++;
            if (op_valid !== 1'b1 || op_a !== held) $display("FAIL stall_hold[%0d]: got v=%b a=%h want v=1 a=%h", c, op_valid, op_a, held);
            else n_pass++;
        end
        op_ready = 1'b1;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", issue_ready);
        else n_pass++;
        step();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== rf_mem[3] || op_b !== rf_mem[4])
            $display("FAIL stall_next: got v=%b a=%h b=%h want v=1 a=%h b=%h", op_valid, op_a, op_b, rf_mem[3], rf_mem[4]);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        idle();
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        step();
        n_checks++;
        if (pending[3] !== 1'b1) $display("FAIL setwins_pre: got %b want 1", pending[3]);
        else n_pass++;
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'h33;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) $display("FAIL setwins_ready: got %b want 1", issue_ready);
        else n_pass++;
        step();
        n_checks++;
        if (pending[3] !== 1'b1) $display("FAIL setwins_bit: got %b want 1", pending[3]);
        else n_pass++;
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        step();
        n_checks++;
        if (pending !== 32'd0) $display("FAIL setwins_clear: got %h want 0", pending);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle();
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = 32'hFF;
        step();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== 32'd0 || op_b !== 32'd0) $display("FAIL x0_operand: got v=%b a=%h b=%h want v=1 a=0 b=0", op_valid, op_a, op_b);
        else n_pass++;
        n_checks++;
        if (pending !== 32'd0) $display("FAIL x0_pending: got %h want 0", pending);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs1      = 5'($urandom_range(0, 7));
            issue_rs2      = 5'($urandom_range(0, 7));
            issue_rd       = 5'($urandom_range(0, 7));
            issue_rd_write = 1'($urandom_range(0, 1));
            op_ready       = ($urandom_range(0, 3) != 0);
            wb_valid       = ($urandom_range(0, 2) == 0);
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            #1;
            n_checks++;
            if (rf_rs1 !== issue_rs1 || rf_rs2 !== issue_rs2) begin
                if (errs < 10) $display("FAIL rand_rfaddr[%0d]: got %0d/%0d want %0d/%0d", c, rf_rs1, rf_rs2, issue_rs1, issue_rs2);
                errs++;
            end else n_pass++;
            n_checks++;
            if (issue_ready !== m_ready()) begin
                if (errs < 10) $display("FAIL rand_ready[%0d]: got %b want %b", c, issue_ready, m_ready());
                errs++;
            end else n_pass++;
            step();
            n_checks++;
            if (op_valid !== m_op_valid || pending !== m_pending_word()) begin
                if (errs < 10) $display("FAIL rand_state[%0d]: got v=%b pend=%h want v=%b pend=%h", c, op_valid, pending, m_op_valid, m_pending_word());
                errs++;
            end else n_pass++;
            if (m_op_valid) begin
                n_checks++;
                if (op_a !== m_op_a || op_b !== m_op_b || op_rd !== m_op_rd || op_rd_write !== m_op_rd_write) begin
                    if (errs < 10) $display("FAIL rand_bundle[%0d]: got a=%h b=%h rd=%0d w=%b want a=%h b=%h rd=%0d w=%b",
                                            c, op_a, op_b, op_rd, op_rd_write, m_op_a, m_op_b, m_op_rd, m_op_rd_write);
                    errs++;
                end else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 1; i < 32; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(i);
            wb_data  = $urandom;
            step();
        end
        idle();
        for (int r = 8; r < 12; r++) begin
            issue(5'd0, 5'd0, 5'(r), 1'b1);
            step();
        end
        idle();
        op_ready = 1'b0;
        step();
        n_checks++;
        if (pending !== 32'h0000_0F00 || op_valid !== 1'b1) $display("FAIL areset_pre: got pend=%h v=%b want 00000f00 v=1", pending, op_valid);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (pending !== 32'd0 || op_valid !== 1'b0 || op_rd !== 5'd0) $display("FAIL areset_async: got pend=%h v=%b rd=%0d want 0 0 0", pending, op_valid, op_rd);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wb_valid = 1'b1;
        wb_rd    = 5'd8;
        wb_data  = 32'h88;
        step();
        n_checks++;
        if (pending !== 32'd0 || op_valid !== 1'b0) $display("FAIL areset_after: got pend=%h v=%b want 0 0", pending, op_valid);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA500_0000 | 32'(i * 257);
        rf_mem[0] = 32'd0;
        rf_mem[5] = 32'h11;
        model_reset();
        test_reset();
        test_basic();
        test_raw_hazard();
        test_stall();
        test_set_wins();
        test_x0();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
